// File: rtl/card_shoe_dealer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | card_shoe_dealer_pkg: card code fields, FSM states, LFSR defaults    |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
package card_shoe_dealer_pkg;

  localparam int unsigned RANK_LSB = 0;
  localparam int unsigned RANK_W   = 4;
  localparam int unsigned SUIT_LSB = 4;
  localparam int unsigned SUIT_W   = 2;
  localparam int unsigned CARD_W   = 8;

  localparam logic [CARD_W-1:0] NO_CARD  = 8'h00;
  localparam logic [RANK_W-1:0] RANK_MIN = 4'd1;
  localparam logic [RANK_W-1:0] RANK_MAX = 4'd13;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SH_PICK = 2'd2,
    ST_SH_SWAP = 2'd3
  } shoe_state_t;

  function automatic logic [CARD_W-1:0] make_card(input logic [SUIT_W-1:0] suit,
                                                  input logic [RANK_W-1:0] rank);
    logic [CARD_W-1:0] c;
    c = NO_CARD;
    c[SUIT_LSB +: SUIT_W] = suit;
    c[RANK_LSB +: RANK_W] = rank;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/card_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | card_lfsr: right-shifting Galois LFSR with seed load (zero -> SEED)  |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module card_lfsr import card_shoe_dealer_pkg::*; #(
  parameter int unsigned          LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]    LFSR_TAPS = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0]    SEED      = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk_dp_i,
  input  logic              rst_dp_i,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_next;

  always_comb begin
    w_next = r_state >> 1;
    if (r_state[0]) begin
      w_next = w_next ^ LFSR_TAPS;
    end
    // A zero seed would lock the register up, so fall back to SEED.
    if (i_load) begin
      w_next = (i_seed == '0) ? SEED : i_seed;
    end
  end

  always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
    if (!rst_dp_i) begin
      r_state <= SEED;
    end else begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/card_shoe_dealer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | card_shoe_dealer: multi-deck shoe, 1-cycle deal, in-place LFSR       |
// | Fisher-Yates shuffle.  Revision: 1.0                                 |
// +--------------------------------------------------------------------+
module card_shoe_dealer import card_shoe_dealer_pkg::*; #(
  parameter int unsigned       NUM_DECKS = 1,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
  parameter int unsigned       CUT_CARDS = 15,
  localparam int unsigned      SHOE_SIZE = 52 * NUM_DECKS,
  localparam int unsigned      IDX_W     = $clog2(SHOE_SIZE),
  localparam int unsigned      CNT_W     = $clog2(SHOE_SIZE + 1)
) (
  input  logic              clk_dp_i,
  input  logic              rst_dp_i,
  input  logic              req_card_i,
  input  logic              shuffle_start_i,
  input  logic              seed_load_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [7:0]        card_o,
  output logic              card_valid_o,
  output logic              req_drop_o,
  output logic [CNT_W-1:0]  cards_left_o,
  output logic              shoe_empty_o,
  output logic              reshuffle_due_o,
  output logic              busy_o
);

  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(SHOE_SIZE - 1);
  localparam logic [CNT_W-1:0] c_FULL     = CNT_W'(SHOE_SIZE);
  localparam logic [CNT_W-1:0] c_CUT      = CNT_W'(CUT_CARDS);

  shoe_state_t       r_state;
  shoe_state_t       w_state_nx;
  logic [7:0]        r_shoe [SHOE_SIZE];
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_j;
  logic [IDX_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_left;
  logic [SUIT_W-1:0] r_suit;
  logic [RANK_W-1:0] r_rank;
  logic [7:0]        r_card;
  logic              r_valid;
  logic              r_drop;

  logic [LFSR_W-1:0] w_lfsr;
  logic [IDX_W-1:0]  w_pick;
  logic              w_lfsr_unused;
  logic              w_deal;
  logic              w_drop;
  logic              w_init_wr;
  logic              w_swap;
  logic              w_start;

  card_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .SEED      (SEED)
  ) u_lfsr (
    .clk_dp_i (clk_dp_i),
    .rst_dp_i (rst_dp_i),
    .i_load   (seed_load_i),
    .i_seed   (seed_i),
    .o_state  (w_lfsr)
  );

  assign w_pick        = w_lfsr[IDX_W-1:0];
  assign w_lfsr_unused = ^w_lfsr;

  always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
    if (!rst_dp_i) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_deal     = 1'b0;
    w_init_wr  = 1'b0;
    w_swap     = 1'b0;
    w_start    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_wr = 1'b1;
        if (r_idx == c_IDX_LAST) begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (shuffle_start_i) begin
          w_start    = 1'b1;
          w_state_nx = ST_SH_PICK;
        end else if (req_card_i && (r_left != '0)) begin
          w_deal = 1'b1;
        end
      end
      // Rejection sampling: redraw until the LFSR index falls within 0..k.
      ST_SH_PICK: begin
        if (w_pick <= r_idx) begin
          w_state_nx = ST_SH_SWAP;
        end
      end
      ST_SH_SWAP: begin
        w_swap     = 1'b1;
        w_state_nx = (r_idx == IDX_W'(1)) ? ST_IDLE : ST_SH_PICK;
      end
      default: w_state_nx = ST_INIT;
    endcase
    w_drop = req_card_i && !w_deal;
  end

  // r_idx is the fill index during INIT and the Fisher-Yates k during shuffle.
  always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
    if (!rst_dp_i) begin
      r_idx   <= '0;
      r_j     <= '0;
      r_ptr   <= '0;
      r_left  <= '0;
      r_suit  <= '0;
      r_rank  <= RANK_MIN;
      r_card  <= NO_CARD;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_valid <= w_deal;
      r_drop  <= w_drop;
      if (w_deal) begin
        r_card <= r_shoe[r_ptr];
        r_ptr  <= r_ptr + 1'b1;
        r_left <= r_left - 1'b1;
      end
      if (w_init_wr) begin
        r_idx <= r_idx + 1'b1;
        if (r_rank == RANK_MAX) begin
          r_rank <= RANK_MIN;
          r_suit <= r_suit + 1'b1;
        end else begin
          r_rank <= r_rank + 1'b1;
        end
      end
      if (w_start) begin
        r_idx <= c_IDX_LAST;
      end
      if (r_state == ST_SH_PICK) begin
        r_j <= w_pick;
      end
      if (w_swap) begin
        r_idx <= r_idx - 1'b1;
      end
      if ((w_init_wr || w_swap) && (w_state_nx == ST_IDLE)) begin
        r_ptr  <= '0;
        r_left <= c_FULL;
      end
    end
  end

  always_ff @(posedge clk_dp_i) begin
    if (w_init_wr) begin
      r_shoe[r_idx] <= make_card(r_suit, r_rank);
    end else if (w_swap) begin
      r_shoe[r_idx] <= r_shoe[r_j];
      r_shoe[r_j]   <= r_shoe[r_idx];
    end
  end

  assign card_o          = r_card;
  assign card_valid_o    = r_valid;
  assign req_drop_o      = r_drop;
  assign cards_left_o    = r_left;
  assign shoe_empty_o    = (r_left == '0);
  assign reshuffle_due_o = (r_left <= c_CUT);
  assign busy_o          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/card_shoe_dealer.md
Name: card_shoe_dealer

Overview:
Parametrised multi-deck card shoe for the blackjack data path. Holds NUM_DECKS×52 card codes in a register array. Deals one card per request with a registered, single-cycle-valid output, and shuffles in place on command with an LFSR-driven Fisher-Yates sequence. It replaces the fixed-table single-deck selector and sits between the game FSM (requests, shuffle commands) and the hand-score logic (card consumer).

Parameters:
NUM_DECKS, 1, decks in the shoe; legal range 1..8.
LFSR_W, 16, LFSR width; must be ≥ IDX_W.
LFSR_TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
SEED, 16'hACE1, LFSR value at reset; must be non-zero.
CUT_CARDS, 15, reshuffle_due_o asserts when cards_left_o ≤ CUT_CARDS.
Derived localparams (not overridable):
- SHOE_SIZE = 52*NUM_DECKS.
- IDX_W = clog2(SHOE_SIZE).
- CNT_W = clog2(SHOE_SIZE+1).

Ports:
clk_dp_i  in  1  clock, rising edge.
rst_dp_i  in  1  reset, asynchronous, active-low.
req_card_i  in  1  deal request, one card per high cycle.
shuffle_start_i  in  1  start-shuffle pulse.
seed_load_i  in  1  load seed_i into the LFSR.
seed_i  in  LFSR_W  new LFSR seed.
card_o  out  8  dealt card code, held between deals.
card_valid_o  out  1  one-cycle strobe marking a new card_o.
req_drop_o  out  1  one-cycle strobe: request ignored.
cards_left_o  out  CNT_W  undealt cards remaining.
shoe_empty_o  out  1  cards_left_o == 0.
reshuffle_due_o  out  1  cards_left_o ≤ CUT_CARDS.
busy_o  out  1  high in INIT or shuffle states.

Behaviour:
- Card code: bits[5:4] = suit 0..3, bits[3:0] = rank 1..13, bits[7:6] = 0. Code 8'h00 means no card.
- Sorted slot i holds: suit = (i mod 52)/13, rank = (i mod 13)+1.
- Reset values:
  - card_o = 0; card_valid_o = 0; req_drop_o = 0; busy_o = 1.
  - cards_left_o = 0; shoe_empty_o = 1; reshuffle_due_o = 1.
  - LFSR = SEED; deal pointer = 0; state = INIT, init index = 0.
  - Shoe array is not reset.
- INIT: writes sorted code to slot i, one slot per cycle, for SHOE_SIZE cycles. Then → IDLE with cards_left = SHOE_SIZE and pointer = 0.
- IDLE, deal path:
  - Condition: req_card_i=1, cards_left>0, and shuffle_start_i=0.
  - Next edge: card_o = shoe[ptr], card_valid_o = 1, ptr+1, cards_left−1.
  - Latency is 1 cycle. Back-to-back requests deal on consecutive cycles.
- Dropped requests: a request in any non-IDLE state, or with cards_left = 0, or coinciding with shuffle_start_i in IDLE is ignored. Effect: req_drop_o = 1 next cycle, card_o unchanged, card_valid_o = 0.
- Shuffle start: shuffle_start_i in IDLE → SH_PICK with k = SHOE_SIZE−1. shuffle_start_i is ignored outside IDLE.
- SH_PICK:
  - j = LFSR[IDX_W-1:0].
  - If j ≤ k → SH_SWAP. Otherwise stay in SH_PICK (rejection sampling).
- SH_SWAP:
  - Exchange shoe[k] and shoe[j]; k−1.
  - If k was 1 → IDLE with ptr = 0 and cards_left = SHOE_SIZE.
  - Otherwise → SH_PICK.
- Shuffle operates on current contents (prior shuffles compound). Dealt cards return to the shoe.
- LFSR advances every clock, in all states.
- seed_load_i: LFSR = seed_i, or SEED if seed_i == 0. It has priority over the advance and is legal in any state.
- Derived outputs: busy_o, shoe_empty_o and reshuffle_due_o are decoded from registered state and count. No combinational input→output paths.
- Reset mid-operation (any state): immediate return to INIT; contents re-sorted.

Decomposition:
- Shared package/header holds:
  - card field positions and widths;
  - NO_CARD = 8'h00;
  - FSM state encoding: INIT, IDLE, SH_PICK, SH_SWAP;
  - default seed and taps.
- One sub-module, card_lfsr: Galois LFSR with parameters LFSR_W and LFSR_TAPS, inputs load/seed, output state; reused by other random blocks.

Test Plan:
- Reset release, NUM_DECKS=1 → busy_o high exactly 52 cycles; then cards_left_o = 52, reshuffle_due_o = 0.
- 52 consecutive requests, no shuffle → cards 8'h01..8'h0D, 8'h11..8'h1D, 8'h21..8'h2D, 8'h31..8'h3D.
  - reshuffle_due_o rises at cards_left = 15.
  - shoe_empty_o rises after the 52nd card.
  - 53rd request → req_drop_o pulse, card_o stays 8'h3D.
- seed_i = 16'h1234, then shuffle, then deal 52 → every code dealt exactly once, order not sorted. Repeating from reset with the same seed → identical sequence.
- Request during shuffle, and request coinciding with shuffle_start_i → req_drop_o pulse each, no card_valid_o, cards_left unchanged until shuffle end.
- NUM_DECKS = 4 → INIT lasts 208 cycles; after a shuffle each of the 52 codes is dealt exactly 4 times.
- Reset asserted mid-SH_SWAP → outputs return to reset values immediately; after INIT, the first deal is 8'h01.
